// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/strobe divider with per-channel one-deep
// ratio staging, glitch-free ratio switch at period wrap, and a shared resync.
module clk_div_prog #(
  parameter  int CHANNELS    = 2,
  parameter  int MAX_DSR     = 16,
  parameter  int DEFAULT_DSR = 4,
  parameter  int CNT_W       = $clog2(MAX_DSR + 1),
  localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clkIn,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      resync,
  input  logic                      cfgValid,
  output logic                      cfgReady,
  input  logic [CHAN_W-1:0]         cfgChan,
  input  logic [CNT_W-1:0]          cfgDsr,
  output logic                      cfgErr,
  output logic [CHANNELS-1:0]       clkOut,
  output logic [CHANNELS-1:0]       strobe,
  output logic [CHANNELS*CNT_W-1:0] cntOut,
  output logic                      aligned
);

  localparam logic [CNT_W-1:0]  DSR_RST  = CNT_W'(DEFAULT_DSR);
  localparam logic [CNT_W-1:0]  DSR_MAX  = CNT_W'(MAX_DSR);
  localparam logic [CHAN_W:0]   CHAN_LIM = (CHAN_W + 1)'(CHANNELS);

  logic                w_chan_ok;
  logic                w_cfg_ok;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_pend_vld;
  logic [CHANNELS-1:0] w_zero;
  logic                r_err;
  logic                r_aligned;

  // Out-of-range channels have no slot, so they always look free and get rejected.
  assign w_chan_ok = ({1'b0, cfgChan} < CHAN_LIM);
  assign w_cfg_ok  = w_chan_ok && (cfgDsr != '0) && (cfgDsr <= DSR_MAX);
  assign cfgReady  = !rst && !(w_chan_ok && w_pend_vld[cfgChan]);
  assign w_xfer    = cfgValid && cfgReady;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_dsr;
      logic [CNT_W-1:0] r_pend_dsr;
      logic             r_pend_vld;
      logic             r_clk;
      logic             r_stb;
      logic             w_wrap;
      logic             w_apply;
      logic             w_wr;
      logic             w_hi;
      logic [CNT_W-1:0] w_cnt_next;
      logic [CNT_W-1:0] w_dsr_next;
      logic [CNT_W:0]   w_half;

      assign w_wrap     = en && (r_cnt == r_dsr - 1'b1);
      assign w_apply    = resync || w_wrap;
      assign w_dsr_next = (w_apply && r_pend_vld) ? r_pend_dsr : r_dsr;
      assign w_cnt_next = resync ? '0 :
                          !en    ? r_cnt :
                          w_wrap ? '0 : r_cnt + 1'b1;
      // High phase is ceil(D/2) so odd ratios favour the high level.
      assign w_half     = ({1'b0, w_dsr_next} + 1'b1) >> 1;
      assign w_hi       = ({1'b0, w_cnt_next} < w_half);
      assign w_wr       = w_xfer && w_cfg_ok && (cfgChan == CHAN_W'(gi));

      always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
          r_cnt      <= '0;
          r_dsr      <= DSR_RST;
          r_pend_dsr <= '0;
          r_pend_vld <= 1'b0;
          r_clk      <= 1'b0;
          r_stb      <= 1'b0;
        end else begin
          r_cnt <= w_cnt_next;
          r_dsr <= w_dsr_next;
          // A write landing on an apply edge refills the slot just freed.
          if (w_wr) begin
            r_pend_vld <= 1'b1;
            r_pend_dsr <= cfgDsr;
          end else if (w_apply) begin
            r_pend_vld <= 1'b0;
          end
          if (resync || en) begin
            r_clk <= w_hi;
          end
          r_stb <= (w_cnt_next == '0) && (en || resync);
        end
      end

      assign w_pend_vld[gi]             = r_pend_vld;
      assign w_zero[gi]                 = (w_cnt_next == '0);
      assign clkOut[gi]                 = r_clk;
      assign strobe[gi]                 = r_stb;
      assign cntOut[gi*CNT_W +: CNT_W]  = r_cnt;
    end
  endgenerate

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_aligned <= 1'b0;
    end else begin
      r_err     <= w_xfer && !w_cfg_ok;
      r_aligned <= &w_zero;
    end
  end

  assign cfgErr  = r_err;
  assign aligned = r_aligned;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised and directed bench for clk_div_prog against a period/modulo
// reference model of each channel.
module tb_clk_div_prog;

  localparam int CH   = 2;
  localparam int MAXD = 16;
  localparam int DEFD = 4;
  localparam int CW   = 5;
  localparam int SW   = CH*CW + 2*CH + 2;

  logic              clkIn = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              resync = 1'b0;
  logic              cfgValid = 1'b0;
  logic [0:0]        cfgChan = '0;
  logic [CW-1:0]     cfgDsr = '0;
  logic              cfgReady;
  logic              cfgErr;
  logic [CH-1:0]     clkOut;
  logic [CH-1:0]     strobe;
  logic [CH*CW-1:0]  cntOut;
  logic              aligned;

  clk_div_prog #(.CHANNELS(CH), .MAX_DSR(MAXD), .DEFAULT_DSR(DEFD)) dut (
    .clkIn(clkIn), .rst(rst), .en(en), .resync(resync),
    .cfgValid(cfgValid), .cfgReady(cfgReady), .cfgChan(cfgChan), .cfgDsr(cfgDsr),
    .cfgErr(cfgErr), .clkOut(clkOut), .strobe(strobe), .cntOut(cntOut), .aligned(aligned)
  );

  always #5 clkIn = ~clkIn;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counter position in period, active ratio, pending ratio (0 = empty).
  int m_cnt[CH];
  int m_d[CH];
  int m_pend[CH];
  bit m_clk[CH];
  bit m_stb[CH];
  bit m_aligned;
  bit m_err;

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0; m_d[k] = DEFD; m_pend[k] = 0; m_clk[k] = 0; m_stb[k] = 0;
    end
    m_aligned = 0;
    m_err = 0;
  endfunction

  function automatic bit model_ready(int c);
    return !rst && (c >= CH || m_pend[c] == 0);
  endfunction

  function automatic void model_edge();
    int c;
    int dsr;
    bit xfer;
    bit bad;
    bit all0;
    bit apply;
    c    = int'(cfgChan);
    dsr  = int'(cfgDsr);
    xfer = cfgValid && model_ready(c);
    bad  = (dsr == 0) || (dsr > MAXD) || (c >= CH);
    all0 = 1;
    for (int k = 0; k < CH; k++) begin
      apply = resync || (en && m_cnt[k] == m_d[k] - 1);
      if (resync) m_cnt[k] = 0;
      else if (en) m_cnt[k] = (m_cnt[k] + 1) % m_d[k];
      if (apply && m_pend[k] != 0) m_d[k] = m_pend[k];
      if (apply) m_pend[k] = 0;
      if (resync || en) begin
        m_clk[k] = (m_cnt[k] < (m_d[k] + 1) / 2);
        m_stb[k] = (m_cnt[k] == 0);
      end else begin
        m_stb[k] = 0;
      end
      if (m_cnt[k] != 0) all0 = 0;
    end
    if (xfer && !bad) m_pend[c] = dsr;
    m_err = xfer && bad;
    m_aligned = all0;
  endfunction

  function automatic logic [SW-1:0] exp_state();
    logic [CH*CW-1:0] c;
    logic [CH-1:0] ck;
    logic [CH-1:0] st;
    for (int k = 0; k < CH; k++) begin
      c[k*CW +: CW] = CW'(m_cnt[k]);
      ck[k] = m_clk[k];
      st[k] = m_stb[k];
    end
    return {c, ck, st, m_aligned, m_err};
  endfunction

  task automatic tick();
    @(posedge clkIn);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({cntOut, clkOut, strobe, aligned, cfgErr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h expected 0", {cntOut, clkOut, strobe, aligned, cfgErr});
    end
    n_checks++;
    if (cfgReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b expected 0", cfgReady);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cfgReady !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready got %b expected 1", cfgReady);
    end
    $display("reset: outputs cleared, ready=%b after release", cfgReady);
  endtask

  task automatic test_default();
    int k;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      k = (i + 1) % 4;
      n_checks++;
      if (cntOut[CW-1:0] !== CW'(k) || clkOut[0] !== (k < 2) || strobe[0] !== (k == 0)) begin
        n_fail++;
        $display("FAIL default_ch0 cycle %0d got cnt=%0d clk=%b stb=%b expected cnt=%0d clk=%b stb=%b",
                 i, cntOut[CW-1:0], clkOut[0], strobe[0], k, (k < 2), (k == 0));
      end
      n_checks++;
      if ({cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL default_state cycle %0d got %h expected %h", i,
                 {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
      end
      $display("default: cycle %0d cnt=%h clk=%b stb=%b aligned=%b", i, cntOut, clkOut, strobe, aligned);
    end
  endtask

  task automatic test_program();
    int cnt_tab[9] = '{2, 3, 0, 1, 2, 3, 4, 0, 1};
    bit clk_tab[9] = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
    bit rdy_tab[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
    int t;
    for (t = 0; t < 20 && cntOut[CW +: CW] !== CW'(1); t++) tick();
    n_checks++;
    if (cntOut[CW +: CW] !== CW'(1)) begin
      n_fail++;
      $display("FAIL program_wait got cnt=%0d expected 1 within 20 cycles", cntOut[CW +: CW]);
    end
    cfgChan = 1'b1; cfgDsr = CW'(5); cfgValid = 1'b1;
    #1;
    n_checks++;
    if (cfgReady !== 1'b1) begin
      n_fail++;
      $display("FAIL program_ready_pre got %b expected 1", cfgReady);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      cfgValid = 1'b0;
      #1;
      n_checks++;
      if (cntOut[CW +: CW] !== CW'(cnt_tab[i]) || clkOut[1] !== clk_tab[i] || cfgReady !== rdy_tab[i]) begin
        n_fail++;
        $display("FAIL program_ch1 step %0d got cnt=%0d clk=%b rdy=%b expected cnt=%0d clk=%b rdy=%b",
                 i, cntOut[CW +: CW], clkOut[1], cfgReady, cnt_tab[i], clk_tab[i], rdy_tab[i]);
      end
      n_checks++;
      if ({cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL program_state step %0d got %h expected %h", i,
                 {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
      end
      $display("program: step %0d ch1 cnt=%0d clk=%b ready=%b", i, cntOut[CW +: CW], clkOut[1], cfgReady);
    end
  endtask

  task automatic test_bad_cfg();
    int bad_tab[2] = '{0, 17};
    for (int i = 0; i < 2; i++) begin
      cfgChan = 1'($urandom_range(0, 1)); cfgDsr = CW'(bad_tab[i]); cfgValid = 1'b1;
      #1;
      n_checks++;
      if (cfgReady !== 1'b1) begin
        n_fail++;
        $display("FAIL badcfg_ready_pre dsr=%0d got %b expected 1", bad_tab[i], cfgReady);
      end
      tick();
      cfgValid = 1'b0;
      #1;
      n_checks++;
      if (cfgErr !== 1'b1 || cfgReady !== 1'b1) begin
        n_fail++;
        $display("FAIL badcfg_pulse dsr=%0d got err=%b rdy=%b expected err=1 rdy=1", bad_tab[i], cfgErr, cfgReady);
      end
      tick();
      n_checks++;
      if (cfgErr !== 1'b0 || {cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL badcfg_after dsr=%0d got %h expected %h", bad_tab[i],
                 {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
      end
      $display("bad_cfg: dsr=%0d chan=%0d err pulse observed=%b", bad_tab[i], cfgChan, cfgErr);
    end
  endtask

  task automatic program_and_wait(input int chan, input int dsr);
    int t;
    cfgChan = 1'(chan); cfgDsr = CW'(dsr); cfgValid = 1'b1;
    for (t = 0; t < 20 && !model_ready(chan); t++) tick();
    tick();
    cfgValid = 1'b0;
    for (t = 0; t < 40 && (m_d[chan] != dsr || m_pend[chan] != 0); t++) tick();
    n_checks++;
    if (m_d[chan] != dsr || {cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
      n_fail++;
      $display("FAIL apply_ch%0d_d%0d got %h expected %h", chan, dsr,
               {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
    end
  endtask

  task automatic test_resync();
    program_and_wait(0, 3);
    program_and_wait(1, 4);
    repeat ($urandom_range(1, 5)) tick();
    cfgChan = 1'b0; cfgDsr = CW'(6); cfgValid = 1'b1;
    tick();
    cfgChan = 1'b1; cfgDsr = CW'(7); resync = 1'b1;
    #1;
    n_checks++;
    if (cfgReady !== model_ready(1)) begin
      n_fail++;
      $display("FAIL resync_ready_pre got %b expected %b", cfgReady, model_ready(1));
    end
    tick();
    resync = 1'b0; cfgValid = 1'b0;
    n_checks++;
    if (cntOut !== '0 || strobe !== 2'b11 || clkOut !== 2'b11 || aligned !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_align got cnt=%h stb=%b clk=%b al=%b expected cnt=0 stb=11 clk=11 al=1",
               cntOut, strobe, clkOut, aligned);
    end
    cfgChan = 1'b0;
    #1;
    n_checks++;
    if (cfgReady !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_ch0_freed got %b expected 1", cfgReady);
    end
    cfgChan = 1'b1;
    #1;
    n_checks++;
    if (cfgReady !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_ch1_landed got %b expected 0", cfgReady);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (cntOut[CW-1:0] !== CW'(i) || {cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL resync_newd step %0d got %h expected %h (ch0 cnt %0d)", i,
                 {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state(), i);
      end
      $display("resync: step %0d cnt=%h clk=%b stb=%b", i, cntOut, clkOut, strobe);
    end
  endtask

  task automatic test_enable();
    int t;
    for (t = 0; t < 30 && cntOut[CW-1:0] !== CW'(1); t++) tick();
    cfgChan = 1'b0; cfgDsr = CW'(3); cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0; en = 1'b0;
    n_checks++;
    if (cntOut[CW-1:0] !== CW'(2)) begin
      n_fail++;
      $display("FAIL enable_setup got cnt=%0d expected 2", cntOut[CW-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (cntOut[CW-1:0] !== CW'(2) || strobe !== 2'b00 || cfgReady !== 1'b0 ||
          {cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL enable_hold step %0d got cnt=%0d stb=%b rdy=%b state=%h expected cnt=2 stb=00 rdy=0 state=%h",
                 i, cntOut[CW-1:0], strobe, cfgReady, {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
      end
      $display("enable: hold %0d cnt=%h stb=%b", i, cntOut, strobe);
    end
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL enable_resume step %0d got %h expected %h", i,
                 {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
      end
      $display("enable: resume %0d cnt=%h clk=%b stb=%b", i, cntOut, clkOut, strobe);
    end
  endtask

  task automatic test_small_ratios();
    logic prev;
    program_and_wait(0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (clkOut[0] !== 1'b1 || strobe[0] !== 1'b1 || cntOut[CW-1:0] !== '0) begin
        n_fail++;
        $display("FAIL d1 step %0d got clk=%b stb=%b cnt=%0d expected clk=1 stb=1 cnt=0",
                 i, clkOut[0], strobe[0], cntOut[CW-1:0]);
      end
      $display("d1: step %0d clk=%b stb=%b", i, clkOut[0], strobe[0]);
    end
    program_and_wait(0, 2);
    prev = clkOut[0];
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (clkOut[0] !== ~prev || {cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL d2 step %0d got clk=%b state=%h expected clk=%b state=%h",
                 i, clkOut[0], {cntOut, clkOut, strobe, aligned, cfgErr}, ~prev, exp_state());
      end
      prev = clkOut[0];
      $display("d2: step %0d clk=%b stb=%b", i, clkOut[0], strobe[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({cntOut, clkOut, strobe, aligned, cfgErr} !== '0 || cfgReady !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got %h rdy=%b expected 0 rdy=0", {cntOut, clkOut, strobe, aligned, cfgErr}, cfgReady);
    end
    $display("async_reset: outputs=%h ready=%b", {cntOut, clkOut, strobe, aligned, cfgErr}, cfgReady);
    @(negedge clkIn);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      resync   = ($urandom_range(0, 29) == 0);
      cfgValid = ($urandom_range(0, 2) == 0);
      cfgChan  = 1'($urandom_range(0, 1));
      cfgDsr   = CW'($urandom_range(0, 18));
      #1;
      n_checks++;
      if (cfgReady !== model_ready(int'(cfgChan))) begin
        n_fail++;
        $display("FAIL random_ready cycle %0d got %b expected %b", i, cfgReady, model_ready(int'(cfgChan)));
      end
      tick();
      n_checks++;
      if ({cntOut, clkOut, strobe, aligned, cfgErr} !== exp_state()) begin
        n_fail++;
        $display("FAIL random_state cycle %0d got %h expected %h", i,
                 {cntOut, clkOut, strobe, aligned, cfgErr}, exp_state());
      end
      $display("random: cycle %0d en=%b rs=%b v=%b ch=%0d dsr=%0d cnt=%h clk=%b stb=%b err=%b",
               i, en, resync, cfgValid, cfgChan, cfgDsr, cntOut, clkOut, strobe, cfgErr);
    end
    resync = 1'b0; cfgValid = 1'b0; en = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default();
    test_program();
    test_bad_cfg();
    test_resync();
    test_enable();
    test_small_ratios();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock/strobe divider. Successor to the fixed-ratio single-output divider.
- Each channel divides clkIn by a runtime-programmable ratio.
- Ratio changes are applied glitch-free at period boundaries.
- A shared resync aligns all channels so that decimation stages in the filter chain can be phase-locked.

Parameters:
- CHANNELS, 2, number of independent divider channels (>=1).
- MAX_DSR, 16, largest accepted divide ratio (>=2).
- DEFAULT_DSR, 4, ratio loaded into every channel at reset (1..MAX_DSR).
- CNT_W, $clog2(MAX_DSR+1), width of counters and ratio fields (derived, do not override).

Ports:
- clkIn  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable, global; when low all counters hold.
- resync  input  1  synchronous restart of all channels.
- cfgValid  input  1  config request.
- cfgReady  output  1  config slot for cfgChan free.
- cfgChan  input  $clog2(CHANNELS) (min 1)  target channel.
- cfgDsr  input  CNT_W  requested ratio.
- cfgErr  output  1  one-cycle pulse: request rejected.
- clkOut  output  CHANNELS  divided clock per channel, registered.
- strobe  output  CHANNELS  one-cycle pulse at counter value 0.
- cntOut  output  CHANNELS*CNT_W  per-channel counter; channel k at bits [k*CNT_W +: CNT_W].
- aligned  output  1  all channel counters are 0 this cycle.

Behaviour:
- Reset (rst=1, async):
  - cnt=0, active ratio D=DEFAULT_DSR, pending slots empty.
  - clkOut=0, strobe=0, aligned=0, cfgErr=0.
  - cfgReady is 0 while rst=1.
- Per channel, each clkIn edge with en=1: cnt_next = (cnt==D-1) ? 0 : cnt+1. With en=0: cnt_next=cnt, and clkOut/strobe hold their values except that strobe is forced to 0.
- Registered outputs:
  - clkOut <= (cnt_next < ceil(D_next/2)).
  - strobe <= (cnt_next==0) & en.
  - The high phase is ceil(D/2) cycles and the low phase floor(D/2) cycles. Odd D gives the longer high phase.
- D=1: cnt stays 0, clkOut constant 1 after the first enabled edge, strobe high every enabled cycle. There is no combinational pass-through of clkIn.
- First period after reset release is truncated: cnt starts at 0 with clkOut=0 and strobe=0, so there is no strobe until the first wrap.
- Config handshake:
  - Transfer occurs on an edge with cfgValid & cfgReady.
  - cfgReady = !rst & pending slot of cfgChan empty (combinational from cfgChan).
  - Requests with cfgDsr==0, cfgDsr>MAX_DSR, or cfgChan>=CHANNELS are still accepted (ready unaffected), but discarded; cfgErr pulses high on the next cycle.
  - A valid request is written to the channel's one-deep pending slot.
- Apply rule:
  - The pending ratio becomes active D on the edge where cnt wraps (cnt==D-1 with en=1). That cycle's cnt_next=0 and clkOut uses the new D.
  - The pending slot frees on the same edge, so cfgReady can reassert the following cycle.
  - While en=0 the pending ratio is not applied.
- Resync:
  - On an edge with resync=1, every cnt_next=0 regardless of en.
  - Any pending ratio is applied immediately and its slot freed.
  - strobe=1 and clkOut=1 next cycle for all channels.
  - resync has priority over wrap and over a simultaneous config transfer to the same channel. The new request lands in the now-empty slot and waits for the next wrap.
- Simultaneous wrap and config write to the same channel is impossible, because cfgReady=0 while the slot is full. A write into an empty slot on the wrap edge does not apply on that edge; it waits for the next wrap.
- aligned <= all cnt_next==0 (registered).
- Mid-operation rst: immediate async return to reset values; pending configs are lost.

Test Plan:
- Reset, then en=1, D=4 default, CHANNELS=2 -> cntOut sequence 1,2,3,0,1,...; clkOut 1,0,0,1,1,0,0 per cycle from the first edge; strobe every 4th cycle; aligned whenever both counters are 0.
- Program ch1 to 5 mid-period (cnt=1) -> old D=4 completes to cnt=3, then ch1 counts 0..4 with clkOut high 3 / low 2 cycles. cfgReady for ch1 is low from the transfer until the wrap edge.
- cfgDsr=0, then cfgDsr=17 with MAX_DSR=16 -> each is accepted, cfgErr pulses for 1 cycle, the active ratio is unchanged, and the slot stays empty.
- ch0 D=3, ch1 D=4 running out of phase, then resync for 1 cycle -> next cycle both cnt=0, strobe=2'b11, aligned=1. A pending ratio on ch0 takes effect immediately.
- en low for 5 cycles at cnt=2 -> counters hold at 2 and strobe stays 0. With a pending config, it is still not applied; it applies at the first wrap after en returns high.
- D=1 and D=2 on ch0 -> D=1: clkOut constant 1, strobe every cycle. D=2: clkOut toggles every cycle, strobe every other cycle. Assert rst mid-period -> all outputs are 0 immediately, asynchronously.
